gzip_framer: RTL and testbench
==============================

Name: gzip_framer

Overview:
- Downstream of the deflate compressor core. Wraps its raw deflate byte stream into a complete RFC 1952 gzip member.
- Prepends the 10-byte gzip header and appends the 8-byte trailer (CRC32, ISIZE), taken from the input-side checksum unit.
- Repacks the result into 32-bit AXI-Stream words for the output FIFO. Byte lane 0 is [7:0] and is the first byte in file order.

Parameters:
OS_BYTE, 8'hFF, header OS field (unknown)
XFL_BYTE, 8'h00, header XFL field
MTIME, 32'h0, header MTIME field, emitted little-endian

Ports:
axis_aclk  in  1  clock
axis_aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  32  deflate payload bytes, lane 0 first
s_axis_tbytes  in  3  valid bytes on tlast beat (1..4, low lanes); ignored (treated as 4) otherwise
s_axis_tlast  in  1  last payload beat of member
s_axis_tvalid  in  1  payload valid
s_axis_tready  out  1  payload accepted
crc_in  in  32  CRC32 of uncompressed data
isize_in  in  32  uncompressed length mod 2^32
trailer_valid  in  1  crc_in/isize_in valid (level)
trailer_ack  out  1  1-cycle pulse when trailer values sampled
m_axis_tdata  out  32  framed gzip bytes
m_axis_tbytes  out  3  valid bytes in word (4 except possibly last)
m_axis_tlast  out  1  final word of member
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output accepted

Behaviour:
- Clock and reset: single clock axis_aclk. axis_aresetn is asynchronous, active-low.
- Reset values: all outputs 0, byte buffer empty, FSM in IDLE. Reset asserted mid-member discards all partial state; the next member starts with a fresh header.
- Logical output stream per member: 1F 8B 08 00, MTIME[7:0..31:24], XFL_BYTE, OS_BYTE, payload bytes, CRC LE, ISIZE LE.
- Output word k carries stream bytes 4k..4k+3.
- Final word: m_axis_tbytes = total mod 4 (4 if 0), unused lanes 0, m_axis_tlast=1.
- FSM states: IDLE, HDR, DATA, WAIT_TRL, TRL, FLUSH.
  - IDLE→HDR: s_axis_tvalid=1. Header begins the next cycle; s_axis_tready=0 in IDLE.
  - HDR: pushes the 10 header bytes into the buffer (4/cycle while room), then →DATA.
  - DATA: s_axis_tready=1 iff the buffer holds ≤3 bytes after this cycle's pop. On an accepted tlast beat: if trailer_valid=1 that cycle, sample crc/isize and →TRL; else →WAIT_TRL.
  - WAIT_TRL: s_axis_tready=0. On the first cycle trailer_valid=1, sample, pulse trailer_ack, →TRL.
  - TRL: pushes 8 trailer bytes, →FLUSH.
  - FLUSH: emits the remaining bytes. When the tlast word handshakes, →IDLE.
- trailer_ack pulses exactly once per member, on the sampling cycle.
- Byte buffer: 8 bytes, count 0..8. Push and pop allowed in the same cycle; count' = count + pushed − popped.
- m_axis_tvalid=1 when count ≥4, or in FLUSH with count>0.
- Back-pressure: while tvalid && !tready, m_axis_tdata, tbytes and tlast are held stable and tvalid stays 1.
- Throughput: 1 word/cycle in steady state with both sides ready. Header-to-first-word latency is 2 cycles after the IDLE tvalid.
- Back-to-back members: the new header may begin the cycle after the previous tlast handshake.

Decomposition:
- Package gzip_pkg:
  - GZIP_ID1=8'h1F, GZIP_ID2=8'h8B, GZIP_CM_DEFLATE=8'h08
  - GZIP_HDR_BYTES=10, GZIP_TRL_BYTES=8
  - FSM state enum
- Sub-module gzip_byte_packer: 8-byte queue, variable push (0..4 bytes), 4-byte pop with count and partial-flush output. The FSM stays in gzip_framer.

Test Plan:
1. Single 4-byte payload 0x44332211, tlast, tbytes=4, trailer_valid=1 with crc=0xDEADBEEF, isize=0x10 → 6 words: 0x00088B1F, 0x00000000, 0x2211FF00, 0xBEEF4433, 0x0010DEAD, 0x00000000. Last word has tlast=1, tbytes=2.
2. 3-byte payload 0x00CCBBAA, tbytes=3 → 21-byte stream. Word 2 = 0xBBAAFF00; last word tbytes=1, tlast=1.
3. Case 1 with m_axis_tready toggling 1,0,1,0 → identical word sequence, outputs stable during every stall cycle, no drop or duplicate.
4. trailer_valid raised 20 cycles after the tlast beat → FSM holds WAIT_TRL with s_axis_tready=0 for 20 cycles. trailer_ack is one pulse, followed by the correct trailer words.
5. axis_aresetn pulsed low after 3 output words → all outputs 0 immediately. The next member emits 0x00088B1F first.
6. Two back-to-back 8-byte members → second header word appears within 2 cycles of the first member's tlast handshake; two trailer_ack pulses total.

Source files
------------

// File: rtl/gzip_pkg.sv
// Shared constants, FSM state type and a small sizing helper for the gzip framer.
package gzip_pkg;

  localparam logic [7:0] GZIP_ID1        = 8'h1F;
  localparam logic [7:0] GZIP_ID2        = 8'h8B;
  localparam logic [7:0] GZIP_CM_DEFLATE = 8'h08;
  localparam logic [7:0] GZIP_FLG        = 8'h00;

  localparam int GZIP_HDR_BYTES = 10;
  localparam int GZIP_TRL_BYTES = 8;
  localparam int GZIP_BUF_BYTES = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR      = 3'd1,
    ST_DATA     = 3'd2,
    ST_WAIT_TRL = 3'd3,
    ST_TRL      = 3'd4,
    ST_FLUSH    = 3'd5
  } gzip_state_e;

  // Bytes to push this cycle: at most one word, no more than is left, no more than fits.
  function automatic logic [2:0] chunk_len(input logic [3:0] remaining, input logic [3:0] room);
    logic [3:0] n;
    n = 4'd4;
    if (remaining < n) n = remaining;
    if (room < n) n = room;
    return n[2:0];
  endfunction

endpackage

// File: rtl/gzip_byte_packer.sv
// 8-byte FIFO-ordered byte queue: pushes 0..4 bytes, pops the head word (4 bytes,
// or whatever is left when fewer than 4 are held). Unoccupied slots are kept zero.
module gzip_byte_packer
  import gzip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] push_data,
  input  logic [2:0]  push_cnt,
  input  logic        pop,
  output logic [31:0] head_word,
  output logic [2:0]  head_bytes,
  output logic [3:0]  count
);

  logic [7:0] bytes_q [GZIP_BUF_BYTES];
  logic [7:0] bytes_d [GZIP_BUF_BYTES];
  logic [3:0] count_q, count_d, keep, src, dst;
  logic [2:0] pop_cnt;

  // Head word view and next-state queue contents: shift out the popped bytes, append pushed ones.
  always_comb begin
    head_bytes = (count_q >= 4'd4) ? 3'd4 : count_q[2:0];
    for (int j = 0; j < 4; j++) head_word[8*j +: 8] = bytes_q[j];
    pop_cnt = pop ? head_bytes : 3'd0;
    keep    = count_q - {1'b0, pop_cnt};
    src     = 4'd0;
    dst     = 4'd0;
    for (int i = 0; i < GZIP_BUF_BYTES; i++) begin
      bytes_d[i] = 8'h00;
      src = 4'(i) + {1'b0, pop_cnt};
      dst = 4'(i) - keep;
      if (src < count_q) bytes_d[i] = bytes_q[src[2:0]];
      else if (dst < {1'b0, push_cnt}) bytes_d[i] = push_data[{dst[1:0], 3'b000} +: 8];
    end
    count_d = keep + {1'b0, push_cnt};
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GZIP_BUF_BYTES; i++) bytes_q[i] <= 8'h00;
      count_q <= 4'd0;
    end else begin
      for (int i = 0; i < GZIP_BUF_BYTES; i++) bytes_q[i] <= bytes_d[i];
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/gzip_framer.sv
// Wraps a raw deflate byte stream into one gzip member: 10-byte header, payload,
// 8-byte trailer (CRC32, ISIZE, little-endian), repacked into 32-bit words.
//
// Handshakes: a beat transfers on a rising edge where valid && ready; a source never
// withdraws valid or changes data before the transfer, and ready may depend on the
// other side combinationally (s_axis_tready follows m_axis_tready through the pop).
module gzip_framer
  import gzip_pkg::*;
#(
  parameter logic [7:0]  OS_BYTE  = 8'hFF,
  parameter logic [7:0]  XFL_BYTE = 8'h00,
  parameter logic [31:0] MTIME    = 32'h0
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic [2:0]  s_axis_tbytes,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] crc_in,
  input  logic [31:0] isize_in,
  input  logic        trailer_valid,
  output logic        trailer_ack,
  output logic [31:0] m_axis_tdata,
  output logic [2:0]  m_axis_tbytes,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  localparam logic [79:0] HDR_VEC = {OS_BYTE, XFL_BYTE, MTIME, GZIP_FLG,
                                     GZIP_CM_DEFLATE, GZIP_ID2, GZIP_ID1};
  localparam logic [3:0]  HDR_LEN = 4'(GZIP_HDR_BYTES);
  localparam logic [3:0]  TRL_LEN = 4'(GZIP_TRL_BYTES);

  gzip_state_e state;
  logic [3:0]  idx_q;     // bytes of header or trailer already pushed
  logic [63:0] trl_q;     // {ISIZE, CRC}: byte 0 is CRC[7:0]

  logic [31:0] head_word, push_data, hdr_word, trl_word;
  logic [2:0]  head_bytes, push_cnt, chunk, beat_bytes;
  logic [3:0]  count, after_pop, room, pos;
  logic        out_valid, out_fire, last_word, s_ready, s_fire, sample_now;

  gzip_byte_packer u_packer (
    .clk        (axis_aclk),
    .rst_n      (axis_aresetn),
    .push_data  (push_data),
    .push_cnt   (push_cnt),
    .pop        (out_fire),
    .head_word  (head_word),
    .head_bytes (head_bytes),
    .count      (count)
  );

  // Output availability, input acceptance and what goes into the packer this cycle.
  always_comb begin
    out_valid  = (count >= 4'd4) || (state == ST_FLUSH && count != 4'd0);
    out_fire   = out_valid && m_axis_tready;
    after_pop  = count - (out_fire ? {1'b0, head_bytes} : 4'd0);
    room       = 4'd8 - after_pop;
    last_word  = (state == ST_FLUSH) && (count != 4'd0) && (count <= 4'd4);
    s_ready    = (state == ST_DATA) && (after_pop <= 4'd3);
    s_fire     = s_ready && s_axis_tvalid;
    beat_bytes = (s_axis_tlast && s_axis_tbytes >= 3'd1 && s_axis_tbytes <= 3'd4)
                 ? s_axis_tbytes : 3'd4;
    sample_now = trailer_valid &&
                 ((state == ST_DATA && s_fire && s_axis_tlast) || state == ST_WAIT_TRL);
    hdr_word = 32'h0;
    trl_word = 32'h0;
    pos      = 4'd0;
    for (int j = 0; j < 4; j++) begin
      pos = idx_q + 4'(j);
      if (pos < HDR_LEN) hdr_word[8*j +: 8] = HDR_VEC[{pos, 3'b000} +: 8];
      if (pos < TRL_LEN) trl_word[8*j +: 8] = trl_q[{pos[2:0], 3'b000} +: 8];
    end
    chunk     = 3'd0;
    push_cnt  = 3'd0;
    push_data = 32'h0;
    case (state)
      ST_HDR: begin
        chunk     = chunk_len(HDR_LEN - idx_q, room);
        push_cnt  = chunk;
        push_data = hdr_word;
      end
      ST_DATA: begin
        if (s_fire) begin
          push_cnt  = beat_bytes;
          push_data = s_axis_tdata;
        end
      end
      ST_TRL: begin
        chunk     = chunk_len(TRL_LEN - idx_q, room);
        push_cnt  = chunk;
        push_data = trl_word;
      end
      default: ;
    endcase
  end

  // Member sequencing: header, payload, trailer capture, trailer, drain.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state <= ST_IDLE;
      idx_q <= 4'd0;
      trl_q <= 64'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx_q <= 4'd0;
          if (s_axis_tvalid) state <= ST_HDR;
        end
        ST_HDR: begin
          idx_q <= idx_q + {1'b0, chunk};
          if (idx_q + {1'b0, chunk} == HDR_LEN) state <= ST_DATA;
        end
        ST_DATA: begin
          idx_q <= 4'd0;
          if (s_fire && s_axis_tlast) begin
            if (trailer_valid) begin
              trl_q <= {isize_in, crc_in};
              state <= ST_TRL;
            end else begin
              state <= ST_WAIT_TRL;
            end
          end
        end
        ST_WAIT_TRL: begin
          if (trailer_valid) begin
            trl_q <= {isize_in, crc_in};
            state <= ST_TRL;
          end
        end
        ST_TRL: begin
          idx_q <= idx_q + {1'b0, chunk};
          if (idx_q + {1'b0, chunk} == TRL_LEN) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          idx_q <= 4'd0;
          // A waiting next member starts its header straight away.
          if (out_fire && last_word) state <= s_axis_tvalid ? ST_HDR : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_tready = s_ready;
  assign trailer_ack   = sample_now;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_valid ? head_word : 32'h0;
  assign m_axis_tbytes = out_valid ? head_bytes : 3'd0;
  assign m_axis_tlast  = out_valid && last_word;

endmodule

// File: tb/tb_gzip_framer.sv
// Bench for gzip_framer: directed members from the test plan plus randomized members,
// each compared word by word against a byte-level gzip stream model.
module tb_gzip_framer;

  localparam int W = 36;  // {tlast, tbytes, tdata}
  localparam logic [7:0]  OS_B  = 8'hFF;
  localparam logic [7:0]  XFL_B = 8'h00;
  localparam logic [31:0] MT    = 32'h0;

  typedef logic [7:0] bq_t[$];

  logic        clk, rst_n;
  logic [31:0] s_axis_tdata;
  logic [2:0]  s_axis_tbytes;
  logic        s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [31:0] crc_in, isize_in;
  logic        trailer_valid, trailer_ack;
  logic [31:0] m_axis_tdata;
  logic [2:0]  m_axis_tbytes;
  logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;

  logic [W-1:0] exp_q[$];
  int checks, errors;
  int ack_cnt, exp_acks, cyc, out_words;
  int tready_mode;
  logic        held_v;
  logic [W:0]  held_vec;
  bit          prev_tlast;
  int          last_tlast_cyc, hdr_gap;

  gzip_framer #(.OS_BYTE(OS_B), .XFL_BYTE(XFL_B), .MTIME(MT)) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tbytes (s_axis_tbytes),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .crc_in        (crc_in),
    .isize_in      (isize_in),
    .trailer_valid (trailer_valid),
    .trailer_ack   (trailer_ack),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tbytes (m_axis_tbytes),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  // clock / cycle counter / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // output ready pattern
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // trailer_ack high cycles
  always @(negedge clk) if (rst_n && trailer_ack) ack_cnt++;

  // scoreboard / stall monitor
  always @(negedge clk) begin
    logic [W-1:0] got, e;
    if (!rst_n) begin
      held_v     = 1'b0;
      prev_tlast = 1'b0;
    end else begin
      if (held_v)
        check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tbytes, m_axis_tdata}, held_vec);
      if (m_axis_tvalid && m_axis_tready) begin
        got = {m_axis_tlast, m_axis_tbytes, m_axis_tdata};
        if (exp_q.size() == 0) begin
          check("extra_word", {27'b0, m_axis_tvalid, got}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("word", got, e);
        end
        out_words++;
        if (prev_tlast) hdr_gap = cyc - last_tlast_cyc;
        prev_tlast = m_axis_tlast;
        if (m_axis_tlast) last_tlast_cyc = cyc;
      end
      held_v   = m_axis_tvalid && !m_axis_tready;
      held_vec = {m_axis_tvalid, m_axis_tlast, m_axis_tbytes, m_axis_tdata};
    end
  end

  // reference model: build the member's byte stream, cut it into words
  task automatic model_member(input bq_t payload, input logic [31:0] crc, input logic [31:0] isize);
    bq_t s;
    int n;
    logic [31:0] d;
    s = {8'h1F, 8'h8B, 8'h08, 8'h00, MT[7:0], MT[15:8], MT[23:16], MT[31:24], XFL_B, OS_B};
    foreach (payload[i]) s.push_back(payload[i]);
    for (int i = 0; i < 4; i++) s.push_back(8'((crc >> (8 * i)) & 32'hFF));
    for (int i = 0; i < 4; i++) s.push_back(8'((isize >> (8 * i)) & 32'hFF));
    for (int k = 0; k < s.size(); k += 4) begin
      n = (s.size() - k < 4) ? s.size() - k : 4;
      d = 32'h0;
      for (int j = 0; j < n; j++) d[8*j +: 8] = s[k + j];
      exp_q.push_back({(k + 4 >= s.size()) ? 1'b1 : 1'b0, 3'(n), d});
    end
  endtask

  // driver tasks (entered and left just after a rising edge)
  task automatic send_beat(input logic [31:0] d, input logic [2:0] tb, input logic last);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tbytes = tb;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("beat_accepted", s_axis_tready, 1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = $urandom;
  endtask

  task automatic send_member(input bq_t p, input logic [31:0] crc, input logic [31:0] isize,
                             input int trl_delay, input int gap_max);
    int nb, n;
    logic [31:0] d;
    logic [2:0] tb;
    logic last;
    model_member(p, crc, isize);
    nb = (p.size() + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      d = $urandom;
      for (int j = 0; j < 4; j++) if (4 * b + j < p.size()) d[8*j +: 8] = p[4 * b + j];
      last = (b == nb - 1);
      tb   = last ? 3'(p.size() - 4 * b) : 3'($urandom_range(0, 7));
      if (last && trl_delay == 0) begin
        crc_in = crc;
        isize_in = isize;
        trailer_valid = 1'b1;
      end
      send_beat(d, tb, last);
    end
    if (trl_delay == 0) begin
      trailer_valid = 1'b0;
      crc_in = $urandom;
      isize_in = $urandom;
    end else begin
      for (int i = 0; i < trl_delay; i++) begin
        @(negedge clk);
        check("wait_trl_sready", s_axis_tready, 0);
        check("wait_trl_ack", trailer_ack, 0);
      end
      @(posedge clk);
      #1;
      crc_in = crc;
      isize_in = isize;
      trailer_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!trailer_ack && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("trl_ack_seen", trailer_ack, 1);
      @(posedge clk);
      #1;
      trailer_valid = 1'b0;
      crc_in = $urandom;
      isize_in = $urandom;
    end
    exp_acks++;
  endtask

  task automatic finish_member();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("ack_count", ack_cnt, exp_acks);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tdata"}, m_axis_tdata, 0);
    check({tag, "_tbytes"}, m_axis_tbytes, 0);
    check({tag, "_tlast"}, m_axis_tlast, 0);
    check({tag, "_sready"}, s_axis_tready, 0);
    check({tag, "_ack"}, trailer_ack, 0);
  endtask

  initial begin
    bq_t p;
    int base, n, len;
    checks = 0; errors = 0; ack_cnt = 0; exp_acks = 0; out_words = 0;
    tready_mode = 0; hdr_gap = 99; last_tlast_cyc = 0;
    rst_n = 1'b0;
    s_axis_tdata = 32'h0; s_axis_tbytes = 3'd0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
    crc_in = 32'h0; isize_in = 32'h0; trailer_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4-byte payload, trailer ready with the last beat
    p = {8'h11, 8'h22, 8'h33, 8'h44};
    send_member(p, 32'hDEADBEEF, 32'h10, 0, 0);
    finish_member();

    // 3-byte payload
    p = {8'hAA, 8'hBB, 8'hCC};
    send_member(p, $urandom, $urandom, 0, 0);
    finish_member();

    // output back-pressure toggling every cycle
    tready_mode = 1;
    p = {8'h11, 8'h22, 8'h33, 8'h44};
    send_member(p, 32'hDEADBEEF, 32'h10, 0, 0);
    finish_member();
    tready_mode = 0;

    // trailer arrives 20 cycles late
    send_member(p, 32'hDEADBEEF, 32'h10, 20, 0);
    finish_member();

    // reset mid-member after three output words
    base = out_words;
    exp_q.push_back({1'b0, 3'd4, 32'h00088B1F});
    exp_q.push_back({1'b0, 3'd4, 32'h00000000});
    exp_q.push_back({1'b0, 3'd4, 32'h2211FF00});
    s_axis_tdata = 32'h44332211; s_axis_tbytes = 3'd4; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    n = 0;
    while (out_words < base + 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("rst_words_seen", out_words - base, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    p = {8'h11, 8'h22, 8'h33, 8'h44};
    send_member(p, 32'hDEADBEEF, 32'h10, 0, 0);
    finish_member();

    // two back-to-back 8-byte members
    hdr_gap = 99;
    p = {};
    for (int i = 0; i < 8; i++) p.push_back(8'($urandom));
    send_member(p, $urandom, $urandom, 0, 0);
    p = {};
    for (int i = 0; i < 8; i++) p.push_back(8'($urandom));
    send_member(p, $urandom, $urandom, 0, 0);
    finish_member();
    check("b2b_gap_le2", (hdr_gap >= 0 && hdr_gap <= 2) ? 1 : 0, 1);

    // randomized members
    for (int m = 0; m < 12; m++) begin
      tready_mode = $urandom_range(0, 2);
      len = $urandom_range(1, 23);
      p = {};
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      send_member(p, $urandom, $urandom, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4), 2);
      finish_member();
    end
    tready_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
